// File: rtl/lbm_pkg.sv
// -----------------------------------------------------------------------------
// lbm_pkg
// Shared definitions for the lattice-Boltzmann time-step sequencer:
//   - phase_t : encoding of the sequencer phase, also driven on the phase port
//   - Q_D2Q9  : number of lattice velocity directions for the D2Q9 model
// -----------------------------------------------------------------------------
package lbm_pkg;

  localparam int Q_D2Q9 = 9;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_INIT    = 3'd1,
    PH_MOMENT  = 3'd2,
    PH_EQUIL   = 3'd3,
    PH_COLLIDE = 3'd4,
    PH_STREAM  = 3'd5,
    PH_DONE    = 3'd6
  } phase_t;

endpackage

// File: rtl/lbm_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// lbm_step_sequencer_if
// Bundles the host handshake and the memory/datapath control bus of the
// sequencer.
//   host side : start, halt, n_iter (to sequencer); busy, done, phase,
//               iter_count (from sequencer)
//   mem side  : rd_addr/rd_dir/rd_valid (issue), wr_addr/wr_dir (write-back),
//               WE_*_mem write enables, select_init
// Modports: master = host / environment, slave = sequencer.
// -----------------------------------------------------------------------------
interface lbm_step_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DIR_WIDTH     = 4,
  parameter int ITER_WIDTH    = 16
);

  logic                     start;
  logic                     halt;
  logic [ITER_WIDTH-1:0]    n_iter;
  logic                     busy;
  logic                     done;
  logic [2:0]               phase;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DIR_WIDTH-1:0]     rd_dir;
  logic                     rd_valid;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DIR_WIDTH-1:0]     wr_dir;
  logic                     WE_p_mem;
  logic                     WE_ux_mem;
  logic                     WE_uy_mem;
  logic                     WE_fin_mem;
  logic                     WE_feq_mem;
  logic                     WE_fout_mem;
  logic                     select_init;
  logic [ITER_WIDTH-1:0]    iter_count;

  modport master (
    output start, halt, n_iter,
    input  busy, done, phase, rd_addr, rd_dir, rd_valid, wr_addr, wr_dir,
    input  WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_feq_mem, WE_fout_mem,
    input  select_init, iter_count
  );

  modport slave (
    input  start, halt, n_iter,
    output busy, done, phase, rd_addr, rd_dir, rd_valid, wr_addr, wr_dir,
    output WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_feq_mem, WE_fout_mem,
    output select_init, iter_count
  );

endinterface

// File: rtl/lbm_delay_line.sv
// -----------------------------------------------------------------------------
// lbm_delay_line
// Shift register carrying {valid, data} through DEPTH stages so the write-back
// address lags the issued address by exactly DEPTH cycles.
//   Clk, Reset (async active-low)  clock and reset
//   flush                          synchronous clear of every valid bit
//   in_valid, in_data              stage-0 input
//   out_valid, out_data            last-stage output (registered)
// -----------------------------------------------------------------------------
module lbm_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH:0]              valid_chain_s;
  logic [DEPTH:0][WIDTH-1:0]   data_chain_s;

  // Next stage contents: everything moves one stage, input enters stage 0.
  always_comb begin
    valid_chain_s = {valid_q, in_valid};
    data_chain_s  = {data_q, in_data};
    valid_d       = valid_chain_s[DEPTH-1:0] & {DEPTH{~flush}};
    data_d        = data_chain_s[DEPTH-1:0];
  end

  // Stage registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/lbm_step_sequencer.sv
// -----------------------------------------------------------------------------
// lbm_step_sequencer
// Time-step engine for the lattice-Boltzmann core. Runs INIT once, then
// MOMENT, EQUIL, COLLIDE, STREAM for n_iter iterations, issuing a cell/direction
// sweep in each phase and raising the matching memory write enables PIPE_LAT
// cycles later.
//   Clk, Reset (async active-low)
//   bus (slave): start/halt/n_iter in; busy, done, phase, iter_count,
//                rd_addr/rd_dir/rd_valid, wr_addr/wr_dir, WE_*_mem,
//                select_init out. All outputs come from registers or are
//                decoded from registers only.
// -----------------------------------------------------------------------------
module lbm_step_sequencer
  import lbm_pkg::*;
#(
  parameter int GRID_X     = 16,
  parameter int GRID_Y     = 16,
  parameter int Q          = Q_D2Q9,
  parameter int PIPE_LAT   = 4,
  parameter int ITER_WIDTH = 16,
  localparam int GRID_DIM      = GRID_X * GRID_Y,
  localparam int ADDRESS_WIDTH = $clog2(GRID_DIM),
  localparam int DIR_WIDTH     = $clog2(Q)
) (
  input  logic Clk,
  input  logic Reset,
  lbm_step_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'(PH_IDLE);
  localparam logic [2:0] S_INIT    = 3'(PH_INIT);
  localparam logic [2:0] S_MOMENT  = 3'(PH_MOMENT);
  localparam logic [2:0] S_EQUIL   = 3'(PH_EQUIL);
  localparam logic [2:0] S_COLLIDE = 3'(PH_COLLIDE);
  localparam logic [2:0] S_STREAM  = 3'(PH_STREAM);
  localparam logic [2:0] S_DONE    = 3'(PH_DONE);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] CELL_LAST  = ADDRESS_WIDTH'(GRID_DIM - 1);
  localparam logic [DIR_WIDTH-1:0]     DIR_LAST   = DIR_WIDTH'(Q - 1);
  localparam logic [DRAIN_W-1:0]       DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cell_q, cell_d;
  logic [DIR_WIDTH-1:0]     dir_q, dir_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  logic [ITER_WIDTH-1:0]    iter_q, iter_d;
  logic [ITER_WIDTH-1:0]    n_iter_q, n_iter_d;

  logic [2:0]                         next_phase_s;
  logic [ITER_WIDTH-1:0]              iter_inc_s;
  logic                               dir_last_s;
  logic                               wr_valid_s;
  logic [ADDRESS_WIDTH+DIR_WIDTH-1:0] wr_data_s;
  logic [DIR_WIDTH-1:0]               wr_dir_s;

  // MOMENT sweeps cells only, so every issue there ends its "direction loop".
  assign dir_last_s = (state_q == S_MOMENT) || (dir_q == DIR_LAST);

  // Phase that follows the current one once its drain completes.
  always_comb begin
    iter_inc_s = iter_q + ITER_WIDTH'(1);
    case (state_q)
      S_INIT:    next_phase_s = (n_iter_q == '0) ? S_DONE : S_MOMENT;
      S_MOMENT:  next_phase_s = S_EQUIL;
      S_EQUIL:   next_phase_s = S_COLLIDE;
      S_COLLIDE: next_phase_s = S_STREAM;
      S_STREAM:  next_phase_s = (iter_inc_s == n_iter_q) ? S_DONE : S_MOMENT;
      default:   next_phase_s = S_IDLE;
    endcase
  end

  // Phase FSM, sweep counters and drain counter.
  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    dir_d      = dir_q;
    rd_valid_d = rd_valid_q;
    drain_d    = drain_q;
    iter_d     = iter_q;
    n_iter_d   = n_iter_q;
    if (bus.halt) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      drain_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            n_iter_d   = bus.n_iter;
            iter_d     = '0;
            state_d    = S_INIT;
            cell_d     = '0;
            dir_d      = '0;
            drain_d    = '0;
            rd_valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_INIT, S_MOMENT, S_EQUIL, S_COLLIDE, S_STREAM: begin
          if (rd_valid_q) begin
            // Issue stage: direction inner loop, cell outer loop.
            if (dir_last_s) begin
              dir_d = '0;
              if (cell_q == CELL_LAST) begin
                rd_valid_d = 1'b0;
              end else begin
                cell_d = cell_q + ADDRESS_WIDTH'(1);
              end
            end else begin
              dir_d = dir_q + DIR_WIDTH'(1);
            end
          end else if (drain_q == DRAIN_LAST) begin
            // Last write has left the delay line: advance.
            iter_d  = (state_q == S_STREAM) ? iter_inc_s : iter_q;
            state_d = next_phase_s;
            drain_d = '0;
            cell_d  = '0;
            dir_d   = '0;
            if (next_phase_s == S_DONE) begin
              rd_valid_d = 1'b0;
            end else begin
              rd_valid_d = 1'b1;
            end
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cell_q     <= '0;
      dir_q      <= '0;
      rd_valid_q <= 1'b0;
      drain_q    <= '0;
      iter_q     <= '0;
      n_iter_q   <= '0;
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      dir_q      <= dir_d;
      rd_valid_q <= rd_valid_d;
      drain_q    <= drain_d;
      iter_q     <= iter_d;
      n_iter_q   <= n_iter_d;
    end
  end

  lbm_delay_line #(
    .WIDTH(ADDRESS_WIDTH + DIR_WIDTH),
    .DEPTH(PIPE_LAT)
  ) u_delay (
    .Clk      (Clk),
    .Reset    (Reset),
    .flush    (bus.halt),
    .in_valid (rd_valid_q),
    .in_data  ({cell_q, dir_q}),
    .out_valid(wr_valid_s),
    .out_data (wr_data_s)
  );

  assign wr_dir_s = wr_data_s[DIR_WIDTH-1:0];

  // Write-enable decode from the delayed valid and the current phase.
  always_comb begin
    bus.WE_p_mem    = 1'b0;
    bus.WE_ux_mem   = 1'b0;
    bus.WE_uy_mem   = 1'b0;
    bus.WE_fin_mem  = 1'b0;
    bus.WE_feq_mem  = 1'b0;
    bus.WE_fout_mem = 1'b0;
    case (state_q)
      S_INIT: begin
        // Macroscopic fields are written once per cell, on direction 0.
        bus.WE_fin_mem = wr_valid_s;
        bus.WE_p_mem   = wr_valid_s & (wr_dir_s == '0);
        bus.WE_ux_mem  = wr_valid_s & (wr_dir_s == '0);
        bus.WE_uy_mem  = wr_valid_s & (wr_dir_s == '0);
      end
      S_MOMENT: begin
        bus.WE_p_mem  = wr_valid_s;
        bus.WE_ux_mem = wr_valid_s;
        bus.WE_uy_mem = wr_valid_s;
      end
      S_EQUIL:   bus.WE_feq_mem  = wr_valid_s;
      S_COLLIDE: bus.WE_fout_mem = wr_valid_s;
      S_STREAM:  bus.WE_fin_mem  = wr_valid_s;
      default:   bus.WE_fin_mem  = 1'b0;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.phase       = state_q;
  assign bus.select_init = (state_q == S_INIT);
  assign bus.rd_addr     = cell_q;
  assign bus.rd_dir      = dir_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_addr     = wr_data_s[DIR_WIDTH +: ADDRESS_WIDTH];
  assign bus.wr_dir      = wr_dir_s;
  assign bus.iter_count  = iter_q;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lbm_step_sequencer
// Self-checking bench for lbm_step_sequencer on a 4x4 D2Q9 grid, PIPE_LAT = 2.
// A per-cycle expected trace is computed from the phase rules (sweep index to
// cell/direction arithmetic, write = issue delayed by PIPE_LAT) and compared
// with the DUT every cycle of each run.
// -----------------------------------------------------------------------------
module tb_lbm_step_sequencer;

  localparam int GX = 4;
  localparam int GY = 4;
  localparam int QD = 9;
  localparam int PL = 2;
  localparam int IW = 16;
  localparam int GD = GX * GY;
  localparam int AW = $clog2(GD);
  localparam int DW = $clog2(QD);

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_INIT = 3'd1;
  localparam logic [2:0] P_MOM  = 3'd2;
  localparam logic [2:0] P_EQ   = 3'd3;
  localparam logic [2:0] P_COL  = 3'd4;
  localparam logic [2:0] P_STR  = 3'd5;
  localparam logic [2:0] P_DONE = 3'd6;

  typedef struct {
    logic [2:0] ph;
    logic       rv;
    int         ra;
    int         rd;
    logic       wv;
    int         wa;
    int         wd;
    logic [5:0] we;   // {p, ux, uy, fin, feq, fout}
    int         it;
  } exp_t;

  typedef struct {
    int n;
    bit rnd;
    int busy_cyc;
    int mom;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  vec_t tbl[4];

  always #5 Clk = ~Clk;

  lbm_step_sequencer_if #(.ADDRESS_WIDTH(AW), .DIR_WIDTH(DW), .ITER_WIDTH(IW)) bus ();

  lbm_step_sequencer #(
    .GRID_X(GX), .GRID_Y(GY), .Q(QD), .PIPE_LAT(PL), .ITER_WIDTH(IW)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic logic [5:0] we_vec();
    return {bus.WE_p_mem, bus.WE_ux_mem, bus.WE_uy_mem,
            bus.WE_fin_mem, bus.WE_feq_mem, bus.WE_fout_mem};
  endfunction

  task automatic check_zero(input string name);
    logic [63:0] v;
    v = 64'({bus.phase, bus.busy, bus.done, bus.rd_valid, bus.rd_addr, bus.rd_dir,
             bus.wr_addr, bus.wr_dir, we_vec(), bus.select_init, bus.iter_count});
    checks++;
    if (v != 64'd0) begin
      errors++;
      $display("FAIL %s: outputs got %h, want all zero", name, v);
    end
  endtask

  // One phase of the expected trace: N issues then PL drain cycles.
  task automatic push_phase(input logic [2:0] ph, input int it);
    int   n;
    int   w;
    exp_t e;
    n = (ph == P_MOM) ? GD : GD * QD;
    for (int c = 0; c < n + PL; c++) begin
      w      = c - PL;
      e.ph   = ph;
      e.it   = it;
      e.rv   = (c < n);
      e.ra   = (ph == P_MOM) ? c : c / QD;
      e.rd   = (ph == P_MOM) ? 0 : c % QD;
      e.wv   = (w >= 0) && (w < n);
      e.wa   = (ph == P_MOM) ? w : w / QD;
      e.wd   = (ph == P_MOM) ? 0 : w % QD;
      e.we   = 6'b000000;
      if (e.wv) begin
        case (ph)
          P_INIT:  e.we = (e.wd == 0) ? 6'b111100 : 6'b000100;
          P_MOM:   e.we = 6'b111000;
          P_EQ:    e.we = 6'b000010;
          P_COL:   e.we = 6'b000001;
          P_STR:   e.we = 6'b000100;
          default: e.we = 6'b000000;
        endcase
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic build_run(input int n);
    exp_t e;
    exp_q.delete();
    push_phase(P_INIT, 0);
    for (int k = 0; k < n; k++) begin
      push_phase(P_MOM, k);
      push_phase(P_EQ, k);
      push_phase(P_COL, k);
      push_phase(P_STR, k);
    end
    e.ph = P_DONE; e.rv = 1'b0; e.ra = 0; e.rd = 0;
    e.wv = 1'b0; e.wa = 0; e.wd = 0; e.we = 6'b000000; e.it = n;
    exp_q.push_back(e);
  endtask

  task automatic check_cycle(input exp_t e, input int cyc);
    logic ok;
    ok = (bus.phase == e.ph) && bus.busy && (bus.done == (e.ph == P_DONE)) &&
         (bus.select_init == (e.ph == P_INIT)) && (bus.rd_valid == e.rv) &&
         (int'(bus.iter_count) == e.it) && (we_vec() == e.we);
    if (e.rv) ok = ok && (int'(bus.rd_addr) == e.ra) && (int'(bus.rd_dir) == e.rd);
    if (e.wv) ok = ok && (int'(bus.wr_addr) == e.wa) && (int'(bus.wr_dir) == e.wd);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL trace cyc=%0d got ph=%0d busy=%0d done=%0d sel=%0d rv=%0d ra=%0d rd=%0d wa=%0d wd=%0d we=%b it=%0d want ph=%0d rv=%0d ra=%0d rd=%0d wv=%0d wa=%0d wd=%0d we=%b it=%0d",
               cyc, bus.phase, bus.busy, bus.done, bus.select_init, bus.rd_valid,
               bus.rd_addr, bus.rd_dir, bus.wr_addr, bus.wr_dir, we_vec(), bus.iter_count,
               e.ph, e.rv, e.ra, e.rd, e.wv, e.wa, e.wd, e.we, e.it);
    end
  endtask

  // Start a run, compare every cycle against the trace, then check aggregates.
  task automatic run_trace(input int n, input bit rnd_start, input int exp_busy, input int exp_mom);
    int busy_cyc, mom_ent, dones, p_init, fin_init;
    logic [2:0] prev_ph;
    busy_cyc = 0; mom_ent = 0; dones = 0; p_init = 0; fin_init = 0;
    prev_ph  = P_IDLE;
    build_run(n);
    bus.n_iter = IW'(n);
    bus.start  = 1'b1;
    bus.halt   = 1'b0;
    tick();
    bus.start  = 1'b0;
    bus.n_iter = IW'($urandom);
    foreach (exp_q[i]) begin
      check_cycle(exp_q[i], i);
      if (bus.busy) busy_cyc++;
      if (bus.phase == P_MOM && prev_ph != P_MOM) mom_ent++;
      if (bus.done) dones++;
      if (bus.phase == P_INIT && bus.WE_p_mem) p_init++;
      if (bus.phase == P_INIT && bus.WE_fin_mem) fin_init++;
      prev_ph   = bus.phase;
      bus.start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    bus.start = 1'b0;
    chk("busy_cycles", busy_cyc, exp_busy);
    chk("moment_entries", mom_ent, exp_mom);
    chk("done_pulses", dones, 1);
    chk("init_we_p_count", p_init, GD);
    chk("init_we_fin_count", fin_init, GD * QD);
    checks++;
    if (!(bus.phase == P_IDLE && !bus.busy && !bus.done && int'(bus.iter_count) == n)) begin
      errors++;
      $display("FAIL after_done: got ph=%0d busy=%0d done=%0d it=%0d, want ph=0 busy=0 done=0 it=%0d",
               bus.phase, bus.busy, bus.done, bus.iter_count, n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{0, 1'b0, 147, 0};
    tbl[1] = '{1, 1'b0, 603, 1};
    tbl[2] = '{3, 1'b1, 1515, 3};
    tbl[3] = '{2, 1'b1, 1059, 2};

    bus.start  = 1'b0;
    bus.halt   = 1'b0;
    bus.n_iter = '0;
    Reset      = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset_state");
    Reset = 1'b1;
    tick();
    check_zero("idle_after_reset");

    // start and halt together in IDLE: halt wins.
    bus.start  = 1'b1;
    bus.halt   = 1'b1;
    bus.n_iter = 16'd1;
    tick();
    chk("start_halt_phase", int'(bus.phase), int'(P_IDLE));
    tick();
    chk("start_halt_busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_trace(tbl[i].n, tbl[i].rnd, tbl[i].busy_cyc, tbl[i].mom);
      tick();
    end

    // halt in the middle of EQUIL.
    bus.n_iter = 16'd1;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (146 + 18 + 40) tick();
    chk("mid_equil_phase", int'(bus.phase), int'(P_EQ));
    chk("mid_equil_we_feq", int'(bus.WE_feq_mem), 1);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("halt_phase", int'(bus.phase), int'(P_IDLE));
    chk("halt_busy", int'(bus.busy), 0);
    chk("halt_iter_hold", int'(bus.iter_count), 0);
    for (int i = 0; i < 10; i++) begin
      chk("post_halt_quiet", int'({we_vec(), bus.done, bus.phase}), 0);
      tick();
    end
    run_trace(1, 1'b0, 603, 1);
    tick();

    // Reset asserted in the middle of COLLIDE, away from any clock edge.
    bus.n_iter = 16'd2;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (146 + 18 + 146 + 30) tick();
    chk("mid_collide_phase", int'(bus.phase), int'(P_COL));
    #2;
    Reset = 1'b0;
    #1;
    check_zero("async_reset_mid_collide");
    Reset = 1'b1;
    tick();
    check_zero("idle_after_mid_reset");

    // Randomised runs with stray start pulses while busy.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) tick();
      run_trace(n, 1'b1, GD * QD + PL + n * (GD * (1 + 3 * QD) + 4 * PL) + 1, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
